// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request, response and memory bus bundle.
// master = requester/memory side, slave = controller side.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_is_store;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_is_store,
    input  resp_rdata, resp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_is_store,
    output resp_rdata, resp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time load/store sequencer to data memory.
// Option: MEM_ACC_ALIGN_CHK_EN rejects odd-address requests with resp_err.
module mem_access_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input logic             clk,
  input logic             reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              is_store_q, is_store_d;
  logic              err_q, err_d;
  logic              accept;
  logic              misalign;

  assign accept = bus.req_valid && (state_q == IDLE);

`ifdef MEM_ACC_ALIGN_CHK_EN
  assign misalign = bus.req_addr[0];
`else
  assign misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (misalign)        state_d = RESP;
          else if (bus.req_we) state_d = WR;
          else                 state_d = RD;
        end
      end
      RD:      state_d = RD_WAIT;
      RD_WAIT: if (cnt_q == 4'd1) state_d = RESP;
      WR:      state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe and handshake decode; only one state drives each strobe
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.mem_read   = (state_q == RD);
    bus.mem_write  = (state_q == WR);
    bus.resp_valid = (state_q == RESP);
  end

  // Request latch, latency countdown and load-data capture
  always_comb begin
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    is_store_d = is_store_q;
    err_d      = err_q;
    if (accept) begin
      addr_d     = bus.req_addr;
      wdata_d    = bus.req_wdata;
      is_store_d = bus.req_we;
      rdata_d    = '0;
      err_d      = misalign;
    end
    if (state_q == RD) begin
      cnt_d = 4'(READ_LATENCY);
    end
    if (state_q == RD_WAIT) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        rdata_d    = bus.mem_rdata;
        is_store_d = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_store_q <= is_store_d;
      err_q      <= err_d;
    end
  end

  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_is_store = is_store_q;
  assign bus.resp_err      = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench, two DUTs (read latency 1 and 3)
// sharing one memory model; sel picks which DUT is stimulated/observed.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_ready;

  int n_chk  = 0;
  int n_pass = 0;
  bit rw_both = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(8), .DATA_W(16)) bus1 ();
  mem_access_ctrl_if #(.ADDR_W(8), .DATA_W(16)) bus3 ();

  mem_access_ctrl #(
    .ADDR_W(8), .DATA_W(16), .READ_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );

  mem_access_ctrl #(
    .ADDR_W(8), .DATA_W(16), .READ_LATENCY(3)
  ) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave)
  );

  assign bus1.req_valid  = req_valid && !sel;
  assign bus1.req_we     = req_we;
  assign bus1.req_addr   = req_addr;
  assign bus1.req_wdata  = req_wdata;
  assign bus1.resp_ready = resp_ready;
  assign bus3.req_valid  = req_valid && sel;
  assign bus3.req_we     = req_we;
  assign bus3.req_addr   = req_addr;
  assign bus3.req_wdata  = req_wdata;
  assign bus3.resp_ready = resp_ready;

  // memory model: data only valid exactly READ_LATENCY cycles after mem_read
  logic [15:0] mem [256];
  logic [3:0]  rc1, rc3;

  always @(posedge clk) begin
    if (reset) begin
      mem[8'h04] <= 16'h1234;
      mem[8'h05] <= 16'h5A5A;
      mem[8'h08] <= 16'hBEEF;
    end else begin
      if (bus1.mem_write) mem[bus1.mem_addr] <= bus1.mem_wdata;
      if (bus3.mem_write) mem[bus3.mem_addr] <= bus3.mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      rc1 <= 4'd0;
      rc3 <= 4'd0;
    end else begin
      if (bus1.mem_read)    rc1 <= 4'd1;
      else if (rc1 != 4'd0) rc1 <= rc1 - 4'd1;
      if (bus3.mem_read)    rc3 <= 4'd3;
      else if (rc3 != 4'd0) rc3 <= rc3 - 4'd1;
    end
  end

  assign bus1.mem_rdata = (rc1 == 4'd1) ? mem[bus1.mem_addr] : 16'hA5A5;
  assign bus3.mem_rdata = (rc3 == 4'd1) ? mem[bus3.mem_addr] : 16'hA5A5;

  always @(negedge clk) begin
    if ((bus1.mem_read && bus1.mem_write) ||
        (bus3.mem_read && bus3.mem_write))
      rw_both <= 1'b1;
  end

  logic        o_req_ready, o_resp_valid, o_is_store, o_err;
  logic        o_mem_read, o_mem_write;
  logic [7:0]  o_mem_addr;
  logic [15:0] o_mem_wdata, o_rdata;

  assign o_req_ready  = sel ? bus3.req_ready     : bus1.req_ready;
  assign o_resp_valid = sel ? bus3.resp_valid    : bus1.resp_valid;
  assign o_is_store   = sel ? bus3.resp_is_store : bus1.resp_is_store;
  assign o_err        = sel ? bus3.resp_err      : bus1.resp_err;
  assign o_mem_read   = sel ? bus3.mem_read      : bus1.mem_read;
  assign o_mem_write  = sel ? bus3.mem_write     : bus1.mem_write;
  assign o_mem_addr   = sel ? bus3.mem_addr      : bus1.mem_addr;
  assign o_mem_wdata  = sel ? bus3.mem_wdata     : bus1.mem_wdata;
  assign o_rdata      = sel ? bus3.resp_rdata    : bus1.resp_rdata;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  int          r_lat, n_rd, n_wr, v_cyc;
  logic [7:0]  s_addr;
  logic [15:0] s_wdata, r_data;
  logic        r_store, r_err;

  // called at the negedge of the handshake cycle; runs until resp drops
  task automatic collect();
    bit seen;
    seen  = 1'b0;
    r_lat = -1;
    n_rd  = 0;
    n_wr  = 0;
    v_cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (o_mem_read) begin
        n_rd++;
        s_addr = o_mem_addr;
      end
      if (o_mem_write) begin
        n_wr++;
        s_addr  = o_mem_addr;
        s_wdata = o_mem_wdata;
      end
      if (o_resp_valid) begin
        if (!seen) begin
          seen    = 1'b1;
          r_lat   = k;
          r_data  = o_rdata;
          r_store = o_is_store;
          r_err   = o_err;
        end
        v_cyc++;
      end else if (seen) begin
        break;
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [7:0] a,
                        input logic [15:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 20 && !o_req_ready; i++) @(negedge clk);
    collect();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int vcount;

  initial begin
    sel        = 1'b0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 8'h00;
    req_wdata  = 16'h0000;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_req_ready", o_req_ready, 1);
    chk("rst_resp_valid", o_resp_valid, 0);
    chk("rst_mem_read", o_mem_read, 0);
    chk("rst_mem_write", o_mem_write, 0);
    chk("rst_rdata", o_rdata, 16'h0000);
    chk("rst_is_store", o_is_store, 0);
    chk("rst_err", o_err, 0);
    chk("rst_mem_addr", o_mem_addr, 8'h00);

    // load 0x04 (preloaded 0x1234), latency 1
    do_req(1'b0, 8'h04, 16'h0000);
    chk("ld1_lat", r_lat, 3);
    chk("ld1_data", r_data, 16'h1234);
    chk("ld1_is_store", r_store, 0);
    chk("ld1_err", r_err, 0);
    chk("ld1_nrd", n_rd, 1);
    chk("ld1_nwr", n_wr, 0);
    chk("ld1_addr", s_addr, 8'h04);
    chk("ld1_vcyc", v_cyc, 1);

    // store 0x04 <- 0xBEEF
    do_req(1'b1, 8'h04, 16'hBEEF);
    chk("st_lat", r_lat, 2);
    chk("st_nwr", n_wr, 1);
    chk("st_nrd", n_rd, 0);
    chk("st_addr", s_addr, 8'h04);
    chk("st_wdata", s_wdata, 16'hBEEF);
    chk("st_is_store", r_store, 1);
    chk("st_rdata", r_data, 16'h0000);
    chk("st_vcyc", v_cyc, 1);
    chk("st_ready_after", o_req_ready, 1);

    // load 0x08 with back-pressure; a new request waits meanwhile
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h08;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !o_resp_valid; i++) @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h04;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", o_resp_valid, 1);
      chk("bp_rdata", o_rdata, 16'hBEEF);
      chk("bp_is_store", o_is_store, 0);
      chk("bp_req_ready", o_req_ready, 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", o_req_ready, 1);
    chk("bp_release_valid", o_resp_valid, 0);
    collect();
    chk("bp_next_lat", r_lat, 3);
    chk("bp_next_data", r_data, 16'hBEEF);
    chk("bp_next_nrd", n_rd, 1);

    // latency-3 DUT: store then load the same word
    @(negedge clk);
    sel = 1'b1;
    do_req(1'b1, 8'h02, 16'hDEAD);
    chk("l3_st_lat", r_lat, 2);
    chk("l3_st_nwr", n_wr, 1);
    chk("l3_st_wdata", s_wdata, 16'hDEAD);
    do_req(1'b0, 8'h02, 16'h0000);
    chk("l3_ld_lat", r_lat, 5);
    chk("l3_ld_data", r_data, 16'hDEAD);
    chk("l3_ld_nrd", n_rd, 1);
    chk("l3_ld_addr", s_addr, 8'h02);
    chk("l3_ld_is_store", r_store, 0);

    // odd address load
    @(negedge clk);
    sel = 1'b0;
    do_req(1'b0, 8'h05, 16'h0000);
`ifdef MEM_ACC_ALIGN_CHK_EN
    chk("odd_lat", r_lat, 1);
    chk("odd_nrd", n_rd, 0);
    chk("odd_nwr", n_wr, 0);
    chk("odd_err", r_err, 1);
    chk("odd_rdata", r_data, 16'h0000);
    chk("odd_is_store", r_store, 0);
    do_req(1'b1, 8'h07, 16'h7777);
    chk("odd_st_lat", r_lat, 1);
    chk("odd_st_nwr", n_wr, 0);
    chk("odd_st_err", r_err, 1);
    chk("odd_st_is_store", r_store, 1);
    do_req(1'b0, 8'h08, 16'h0000);
    chk("even_err", r_err, 0);
    chk("even_data", r_data, 16'hBEEF);
`else
    chk("odd_lat", r_lat, 3);
    chk("odd_nrd", n_rd, 1);
    chk("odd_addr", s_addr, 8'h05);
    chk("odd_err", r_err, 0);
    chk("odd_rdata", r_data, 16'h5A5A);
`endif

    // reset during RD_WAIT drops the load
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h04;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_rd_strobe", o_mem_read, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_ready", o_req_ready, 1);
    chk("mid_rst_valid", o_resp_valid, 0);
    chk("mid_rst_mem_read", o_mem_read, 0);
    chk("mid_rst_mem_write", o_mem_write, 0);
    chk("mid_rst_rdata", o_rdata, 16'h0000);
    chk("mid_rst_mem_addr", o_mem_addr, 8'h00);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_resp_valid) vcount++;
    end
    chk("mid_rst_no_resp", vcount, 0);

    chk("rw_overlap", rw_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
